// File: rtl/regfile_arb_pkg.sv
// Purpose: shared definitions for the register-file port arbiter slice.
//   - default register file geometry
//   - pointer-width helper used by the arbiter and its round-robin pickers
//   - widest grant vector type supported by the arbiter (NUM_REQ <= MAX_REQ)
// Ports: none (package).
// Build option: REGFILE_ARB_BYPASS_EN (used by regfile_port_arbiter).
package regfile_arb_pkg;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_DATA_W = 8;
    localparam int MAX_REQ        = 8;

    // One-hot grant vector at the maximum supported requester count.
    typedef logic [MAX_REQ-1:0] grant_t;

    // Width of a requester index; never below 1 so two requesters still get a bit.
    function automatic int ptrWidth(input int numReq);
        return (numReq <= 2) ? 1 : $clog2(numReq);
    endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_pick.sv
// Purpose: combinational round-robin picker. Returns the first asserted
//   request found when searching upward from ptr, wrapping at N.
// Ports:
//   req   in  [N-1:0]   request vector
//   ptr   in  [PW-1:0]  highest-priority index (must be < N)
//   grant out [N-1:0]   one-hot grant (all zero when nothing requests)
//   idx   out [PW-1:0]  index of the granted request (0 when none)
//   found out           at least one request was granted
module rr_pick
    import regfile_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptrWidth(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          found
);

    always_comb begin
        logic [PW-1:0] cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = PW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Purpose: shares one register file (1 write port, 2 combinational read ports)
//   among NUM_REQ requesters. Each cycle grants at most one write and up to two
//   reads with independent round-robin pointers, and returns read data on a
//   registered one-cycle response pulse.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_we     per-requester valid and write(1)/read(0) select
//   req_addr/req_wdata   packed per-requester address and write data
//   req_ready            per-requester grant
//   rsp_valid/rsp_rdata  per-requester read response (latency 1)
//   rf_we/rf_waddr/rf_wdata       register file write port
//   rf_raddr1/rf_raddr2           register file read addresses
//   rf_rdata1/rf_rdata2           register file read data (combinational)
// Build option: REGFILE_ARB_BYPASS_EN
//   undefined: a read hitting the address being written this cycle is held off
//              and granted later, so it observes the committed value.
//   defined:   such a read is granted and its response takes the write data.
//
// Handshake: a request transfers on a cycle where req_valid && req_ready at the
// rising edge. A requester keeps req_we/req_addr/req_wdata stable while it is
// valid and not ready. req_ready is combinational from the current requests and
// is forced low while rst is high.
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0] rsp_rdata,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [ADDR_W-1:0]         rf_raddr1,
    output logic [ADDR_W-1:0]         rf_raddr2,
    input  logic [DATA_W-1:0]         rf_rdata1,
    input  logic [DATA_W-1:0]         rf_rdata2
);

    localparam int PTR_W = ptrWidth(NUM_REQ);

    logic [PTR_W-1:0]   wrPtr, rdPtr;
    logic [NUM_REQ-1:0] wrCand, rdCand, rd2Cand, hazardBlock;
    logic [NUM_REQ-1:0] wrGrant, rd1Grant, rd2Grant;
    logic [PTR_W-1:0]   wrIdx, rd1Idx, rd2Idx;
    logic               wrFound, rd1Found, rd2Found;
    logic               wrGo, rd1Go, rd2Go;
    logic [ADDR_W-1:0]  wrAddr, rd1Addr, rd2Addr;
    logic [DATA_W-1:0]  wrData;
    logic [DATA_W-1:0]  rsp1Data, rsp2Data;

    function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
        return (int'(p) == NUM_REQ - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // ---------------- write arbitration ----------------
    assign wrCand = req_valid & req_we;

    rr_pick #(.N(NUM_REQ)) wrPick (
        .req   (wrCand),
        .ptr   (wrPtr),
        .grant (wrGrant),
        .idx   (wrIdx),
        .found (wrFound)
    );

    assign wrGo = wrFound & ~rst;

    always_comb begin
        wrAddr = '0;
        wrData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wrGrant[i]) begin
                wrAddr = req_addr[i*ADDR_W +: ADDR_W];
                wrData = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // ---------------- read/write hazard ----------------
`ifdef REGFILE_ARB_BYPASS_EN
    // Matching reads proceed; their response is patched with the write data.
    assign hazardBlock = '0;
`else
    // A read to the address being written this cycle waits for the commit.
    always_comb begin
        hazardBlock = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hazardBlock[i] = wrGo && (req_addr[i*ADDR_W +: ADDR_W] == wrAddr);
        end
    end
`endif

    // ---------------- read arbitration ----------------
    assign rdCand = req_valid & ~req_we & ~hazardBlock;

    rr_pick #(.N(NUM_REQ)) rd1Pick (
        .req   (rdCand),
        .ptr   (rdPtr),
        .grant (rd1Grant),
        .idx   (rd1Idx),
        .found (rd1Found)
    );

    // Searching from rdPtr with R1 removed yields the next reader after R1,
    // since nothing between rdPtr and R1 was requesting.
    assign rd2Cand = rdCand & ~rd1Grant;

    rr_pick #(.N(NUM_REQ)) rd2Pick (
        .req   (rd2Cand),
        .ptr   (rdPtr),
        .grant (rd2Grant),
        .idx   (rd2Idx),
        .found (rd2Found)
    );

    assign rd1Go = rd1Found & ~rst;
    assign rd2Go = rd2Found & ~rst;

    always_comb begin
        rd1Addr = '0;
        rd2Addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd1Grant[i]) rd1Addr = req_addr[i*ADDR_W +: ADDR_W];
            if (rd2Grant[i]) rd2Addr = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // ---------------- register file and grant outputs ----------------
    assign req_ready = {NUM_REQ{~rst}} & (wrGrant | rd1Grant | rd2Grant);
    assign rf_we     = wrGo;
    assign rf_waddr  = wrGo  ? wrAddr  : '0;
    assign rf_wdata  = wrGo  ? wrData  : '0;
    assign rf_raddr1 = rd1Go ? rd1Addr : '0;
    assign rf_raddr2 = rd2Go ? rd2Addr : '0;

`ifdef REGFILE_ARB_BYPASS_EN
    assign rsp1Data = (wrGo && (rd1Addr == wrAddr)) ? wrData : rf_rdata1;
    assign rsp2Data = (wrGo && (rd2Addr == wrAddr)) ? wrData : rf_rdata2;
`else
    assign rsp1Data = rf_rdata1;
    assign rsp2Data = rf_rdata2;
`endif

    // ---------------- pointers and responses ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            if (wrGo) wrPtr <= incPtr(wrIdx);
            // The last reader granted is R2 when both ports were used.
            if (rd2Go)      rdPtr <= incPtr(rd2Idx);
            else if (rd1Go) rdPtr <= incPtr(rd1Idx);
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid[i] <= (rd1Go && rd1Grant[i]) || (rd2Go && rd2Grant[i]);
                if (rd1Go && rd1Grant[i])
                    rsp_rdata[i*DATA_W +: DATA_W] <= rsp1Data;
                else if (rd2Go && rd2Grant[i])
                    rsp_rdata[i*DATA_W +: DATA_W] <= rsp2Data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Purpose: self-checking bench for regfile_port_arbiter (NUM_REQ=4, ADDR_W=5,
//   DATA_W=8) with a behavioural register file attached to the rf_* ports.
//   Expected values are hand-computed per cycle in a vector table; reset and
//   mid-operation reset are hand-written sequences.
// Build option: REGFILE_ARB_BYPASS_EN changes the expected hazard behaviour.
module tb_regfile_port_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_we;
    logic [19:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [7:0]  rf_rdata1;
    logic [7:0]  rf_rdata2;

    int errors = 0;
    int checks = 0;

    regfile_port_arbiter #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- register file model ----------------
    // Location i starts at 8'h80|i; loaded on the first edge (held in reset).
    logic [7:0] rfMem [0:31];
    logic       memLoaded = 1'b0;

    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 32; i++) rfMem[i] <= 8'h80 | 8'(i);
            memLoaded <= 1'b1;
        end else if (rf_we) begin
            rfMem[rf_waddr] <= rf_wdata;
        end
    end

    assign rf_rdata1 = rfMem[rf_raddr1];
    assign rf_rdata2 = rfMem[rf_raddr2];

    // ---------------- vector table ----------------
    typedef struct {
        logic        rstIn;
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [3:0]  expReady;
        logic        expRfWe;
        logic [4:0]  expWaddr;
        logic [7:0]  expWdata;
        logic [4:0]  expRaddr1;
        logic [4:0]  expRaddr2;
        logic [3:0]  expRspValid;
        logic [31:0] expRspData;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic        r,
        input logic [3:0]  va,
        input logic [3:0]  w,
        input logic [19:0] ad,
        input logic [31:0] wd,
        input logic [3:0]  rdy,
        input logic        rfwe,
        input logic [4:0]  wa,
        input logic [7:0]  wdt,
        input logic [4:0]  ra1,
        input logic [4:0]  ra2,
        input logic [3:0]  rv,
        input logic [31:0] rd
    );
        vec_t v;
        v.rstIn = r; v.valid = va; v.we = w; v.addr = ad; v.wdata = wd;
        v.expReady = rdy; v.expRfWe = rfwe; v.expWaddr = wa; v.expWdata = wdt;
        v.expRaddr1 = ra1; v.expRaddr2 = ra2; v.expRspValid = rv; v.expRspData = rd;
        return v;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkRspLane(input string name, input int lane, input logic [7:0] exp);
        check($sformatf("%s rsp_rdata[%0d]", name, lane), 32'(rsp_rdata[lane*8 +: 8]), 32'(exp));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        req_we    = 4'b0101;
        req_addr  = {5'd3, 5'd2, 5'd1, 5'd0};
        req_wdata = 32'h44332211;

        // Reset held for two edges with every requester active.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #2;
            check($sformatf("reset%0d req_ready", c), 32'(req_ready), 32'h0);
            check($sformatf("reset%0d rf_we", c), 32'(rf_we), 32'h0);
            check($sformatf("reset%0d rf_raddr1", c), 32'(rf_raddr1), 32'h0);
            check($sformatf("reset%0d rsp_valid", c), 32'(rsp_valid), 32'h0);
        end
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);

        // Addresses packed {a3,a2,a1,a0}, data packed {d3,d2,d1,d0}.
        // v0: req0 writes addr0=07
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 20'h0, 32'h07,
                         4'b0001, 1, 5'd0, 8'h07, 5'd0, 5'd0, 4'b0000, 32'h0));
        // v1: req1 reads addr0
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 20'h0, 32'h0,
                         4'b0010, 0, 5'd0, 8'h00, 5'd0, 5'd0, 4'b0000, 32'h0));
        // v2: idle, response for req1 = 07
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 20'h0, 32'h0,
                         4'b0000, 0, 5'd0, 8'h00, 5'd0, 5'd0, 4'b0010, 32'h0000_0700));
        // v3: reset to bring both pointers back to 0
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 20'h0, 32'h0,
                         4'b0000, 0, 5'd0, 8'h00, 5'd0, 5'd0, 4'b0000, 32'h0));
        // v4..v7: all four write addr 1..4; each drops after its grant
        tbl.push_back(mk(0, 4'b1111, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 32'h14131211,
                         4'b0001, 1, 5'd1, 8'h11, 5'd0, 5'd0, 4'b0000, 32'h0));
        tbl.push_back(mk(0, 4'b1110, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 32'h14131211,
                         4'b0010, 1, 5'd2, 8'h12, 5'd0, 5'd0, 4'b0000, 32'h0));
        tbl.push_back(mk(0, 4'b1100, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 32'h14131211,
                         4'b0100, 1, 5'd3, 8'h13, 5'd0, 5'd0, 4'b0000, 32'h0));
        tbl.push_back(mk(0, 4'b1000, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 32'h14131211,
                         4'b1000, 1, 5'd4, 8'h14, 5'd0, 5'd0, 4'b0000, 32'h0));
        // v8: all four again, pointer wrapped so req0 wins
        tbl.push_back(mk(0, 4'b1111, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 32'h24232221,
                         4'b0001, 1, 5'd1, 8'h21, 5'd0, 5'd0, 4'b0000, 32'h0));
        // v9: req0..2 read addr3 -> req0 port1, req1 port2
        tbl.push_back(mk(0, 4'b0111, 4'b0000, {5'd0, 5'd3, 5'd3, 5'd3}, 32'h0,
                         4'b0011, 0, 5'd0, 8'h00, 5'd3, 5'd3, 4'b0000, 32'h0));
        // v10: req2 granted alone; req0/req1 get 13
        tbl.push_back(mk(0, 4'b0100, 4'b0000, {5'd0, 5'd3, 5'd3, 5'd3}, 32'h0,
                         4'b0100, 0, 5'd0, 8'h00, 5'd3, 5'd0, 4'b0011, 32'h0000_1313));
        // v11: req0 writes addr5=55 while req3 reads addr2 and req1 reads addr4
        tbl.push_back(mk(0, 4'b1011, 4'b0001, {5'd2, 5'd0, 5'd4, 5'd5}, 32'h55,
                         4'b1011, 1, 5'd5, 8'h55, 5'd2, 5'd4, 4'b0100, 32'h0013_0000));
`ifdef REGFILE_ARB_BYPASS_EN
        // v12: req0 writes addr1=09, req1 reads addr1 in the same cycle
        tbl.push_back(mk(0, 4'b0011, 4'b0001, {5'd0, 5'd0, 5'd1, 5'd1}, 32'h09,
                         4'b0011, 1, 5'd1, 8'h09, 5'd1, 5'd0, 4'b1010, 32'h1200_1400));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 20'h0, 32'h0,
                         4'b0000, 0, 5'd0, 8'h00, 5'd0, 5'd0, 4'b0010, 32'h0000_0900));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 20'h0, 32'h0,
                         4'b0000, 0, 5'd0, 8'h00, 5'd0, 5'd0, 4'b0000, 32'h0));
`else
        // v12: req0 writes addr1=09, req1 reads addr1 -> read held off
        tbl.push_back(mk(0, 4'b0011, 4'b0001, {5'd0, 5'd0, 5'd1, 5'd1}, 32'h09,
                         4'b0001, 1, 5'd1, 8'h09, 5'd0, 5'd0, 4'b1010, 32'h1200_1400));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, {5'd0, 5'd0, 5'd1, 5'd0}, 32'h0,
                         4'b0010, 0, 5'd0, 8'h00, 5'd1, 5'd0, 4'b0000, 32'h0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 20'h0, 32'h0,
                         4'b0000, 0, 5'd0, 8'h00, 5'd0, 5'd0, 4'b0010, 32'h0000_0900));
`endif

        for (int n = 0; n < tbl.size(); n++) begin
            vec_t v;
            string tag;
            v         = tbl[n];
            tag       = $sformatf("v%0d", n);
            rst       = v.rstIn;
            req_valid = v.valid;
            req_we    = v.we;
            req_addr  = v.addr;
            req_wdata = v.wdata;
            #2;
            check({tag, " req_ready"}, 32'(req_ready), 32'(v.expReady));
            check({tag, " rf_we"}, 32'(rf_we), 32'(v.expRfWe));
            if (v.expRfWe) begin
                check({tag, " rf_waddr"}, 32'(rf_waddr), 32'(v.expWaddr));
                check({tag, " rf_wdata"}, 32'(rf_wdata), 32'(v.expWdata));
            end
            check({tag, " rf_raddr1"}, 32'(rf_raddr1), 32'(v.expRaddr1));
            check({tag, " rf_raddr2"}, 32'(rf_raddr2), 32'(v.expRaddr2));
            check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(v.expRspValid));
            for (int l = 0; l < 4; l++) begin
                if (v.expRspValid[l]) checkRspLane(tag, l, v.expRspData[l*8 +: 8]);
            end
            @(negedge clk);
        end

        // Mid-operation reset: req2 is granted (rdPtr=2), then rst rises
        // before the capturing edge so no response may appear.
        rst       = 1'b0;
        req_valid = 4'b0100;
        req_we    = 4'b0000;
        req_addr  = {5'd0, 5'd3, 5'd0, 5'd0};
        req_wdata = 32'h0;
        #2;
        check("midrst req_ready", 32'(req_ready), 32'b0100);
        check("midrst rf_raddr1", 32'(rf_raddr1), 32'd3);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #2;
        check("midrst rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst ready in reset", 32'(req_ready), 32'h0);

        // After reset rdPtr must be 0: req0 (addr7) on port 1, req3 (addr8) on port 2.
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b1001;
        req_addr  = {5'd8, 5'd0, 5'd0, 5'd7};
        #2;
        check("postrst req_ready", 32'(req_ready), 32'b1001);
        check("postrst rf_raddr1", 32'(rf_raddr1), 32'd7);
        check("postrst rf_raddr2", 32'(rf_raddr2), 32'd8);
        check("postrst rsp_valid", 32'(rsp_valid), 32'h0);
        check("postrst rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        req_valid = 4'b0000;
        #2;
        check("postrst rsp_valid next", 32'(rsp_valid), 32'b1001);
        checkRspLane("postrst", 0, 8'h87);
        checkRspLane("postrst", 3, 8'h88);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
